// File: rtl/hc595_frame_receiver.sv
// Receive end of the 74HC595 three-wire link: synchronises SH_CP/ST_CP/DS into Clk,
// deserialises MSB-first frames and flags frames of the wrong length.
module hc595_frame_receiver #(
    parameter int unsigned DATA_WIDTH  = 15,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ERR_CNT_W   = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  SH_CP,
    input  logic                  ST_CP,
    input  logic                  DS,
    output logic [DATA_WIDTH-1:0] Data,
    output logic                  Data_valid,
    output logic                  Frame_err,
    output logic [ERR_CNT_W-1:0]  Err_cnt,
    output logic                  Busy
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 2);
    localparam logic [CntW-1:0] CntFull = CntW'(DATA_WIDTH);
    localparam logic [CntW-1:0] CntOver = CntW'(DATA_WIDTH + 1);
    localparam logic [ERR_CNT_W-1:0] ErrMax = {ERR_CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sh_sync_q, st_sync_q, ds_sync_q;
    logic                   sh_hist_q, st_hist_q;
    logic                   sh_rise, st_rise, ds_bit;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic                  busy_q;

    // DS uses the same chain depth as the clocks so the sampled bit lines up with its edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sh_sync_q <= '0;
            st_sync_q <= '0;
            ds_sync_q <= '0;
            sh_hist_q <= 1'b0;
            st_hist_q <= 1'b0;
        end else begin
            sh_sync_q <= {sh_sync_q[SYNC_STAGES-2:0], SH_CP};
            st_sync_q <= {st_sync_q[SYNC_STAGES-2:0], ST_CP};
            ds_sync_q <= {ds_sync_q[SYNC_STAGES-2:0], DS};
            sh_hist_q <= sh_sync_q[SYNC_STAGES-1];
            st_hist_q <= st_sync_q[SYNC_STAGES-1];
        end
    end

    assign sh_rise = sh_sync_q[SYNC_STAGES-1] & ~sh_hist_q;
    assign st_rise = st_sync_q[SYNC_STAGES-1] & ~st_hist_q;
    assign ds_bit  = ds_sync_q[SYNC_STAGES-1];

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        // Latch judges the pre-edge count; an empty latch (count 0) is silent.
        if (st_rise) begin
            if (cnt_q == CntFull) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else if (cnt_q != '0) begin
                err_d = 1'b1;
                if (err_cnt_q != ErrMax) begin
                    err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                end
            end
            cnt_d = '0;
        end

        // A coincident shift starts the next frame with this bit.
        if (sh_rise) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], ds_bit};
            if (st_rise) begin
                cnt_d = CntW'(1);
            end else if (cnt_q != CntOver) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            busy_q    <= (cnt_d != '0);
        end
    end

    assign Data       = data_q;
    assign Data_valid = valid_q;
    assign Frame_err  = err_q;
    assign Err_cnt    = err_cnt_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_hc595_frame_receiver.sv
// Bench for hc595_frame_receiver: pin-level frame model with a latency pipe, compared every
// cycle, plus directed scenarios with literal expectations.
module tb_hc595_frame_receiver;

    localparam int DW = 15;
    localparam int SS = 2;
    localparam int EW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          valid;
        logic          err;
        logic [EW-1:0] err_cnt;
        logic          busy;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          SH_CP = 1'b0;
    logic          ST_CP = 1'b0;
    logic          DS = 1'b0;
    logic [DW-1:0] Data;
    logic          Data_valid;
    logic          Frame_err;
    logic [EW-1:0] Err_cnt;
    logic          Busy;

    hc595_frame_receiver #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(SS),
        .ERR_CNT_W  (EW)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .SH_CP     (SH_CP),
        .ST_CP     (ST_CP),
        .DS        (DS),
        .Data      (Data),
        .Data_valid(Data_valid),
        .Frame_err (Frame_err),
        .Err_cnt   (Err_cnt),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int hold = 2;
    bit started = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame = list of bits seen at SH_CP pin rises, judged at ST_CP rises.
    bit            bits[$];
    bit            prev_sh = 0, prev_st = 0;
    logic [DW-1:0] m_data = '0;
    logic [EW-1:0] m_err_cnt = '0;
    exp_t          pipe[0:SS] = '{default: '0};

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bits.delete();
            prev_sh = 0;
            prev_st = 0;
            m_data = '0;
            m_err_cnt = '0;
            for (int i = 0; i <= SS; i++) pipe[i] = '0;
        end else begin
            bit sh_r, st_r, nv, ne;
            logic [DW-1:0] w;
            sh_r = SH_CP && !prev_sh;
            st_r = ST_CP && !prev_st;
            prev_sh = SH_CP;
            prev_st = ST_CP;
            nv = 0;
            ne = 0;
            if (st_r) begin
                if (bits.size() == DW) begin
                    w = '0;
                    for (int i = 0; i < DW; i++) w = {w[DW-2:0], bits[i]};
                    m_data = w;
                    nv = 1;
                end else if (bits.size() != 0) begin
                    ne = 1;
                    if (m_err_cnt != {EW{1'b1}}) m_err_cnt = m_err_cnt + 1;
                end
                bits.delete();
            end
            if (sh_r) bits.push_back(DS);
            for (int i = SS; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = '{data: m_data, valid: nv, err: ne, err_cnt: m_err_cnt,
                        busy: (bits.size() != 0)};
        end
    end

    // Per-cycle comparison plus pulse monitors.
    logic [DW-1:0] cap_q[$];
    int valid_seen = 0;
    int err_seen = 0;

    always @(negedge Clk) begin
        if (started) begin
            check("cyc_data", 32'(Data), 32'(pipe[SS].data));
            check("cyc_valid", 32'(Data_valid), 32'(pipe[SS].valid));
            check("cyc_err", 32'(Frame_err), 32'(pipe[SS].err));
            check("cyc_err_cnt", 32'(Err_cnt), 32'(pipe[SS].err_cnt));
            check("cyc_busy", 32'(Busy), 32'(pipe[SS].busy));
        end
        if (Data_valid) begin
            valid_seen++;
            cap_q.push_back(Data);
        end
        if (Frame_err) err_seen++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic shift_bit(input bit b);
        DS = b;
        wait_cycles(hold);
        SH_CP = 1'b1;
        wait_cycles(hold);
        SH_CP = 1'b0;
        wait_cycles(hold);
    endtask

    task automatic shift_word(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic latch();
        ST_CP = 1'b1;
        wait_cycles(hold);
        ST_CP = 1'b0;
        wait_cycles(hold + 2);
    endtask

    task automatic coincident(input bit b);
        DS = b;
        wait_cycles(hold);
        SH_CP = 1'b1;
        ST_CP = 1'b1;
        wait_cycles(hold);
        SH_CP = 1'b0;
        ST_CP = 1'b0;
        wait_cycles(hold + 2);
    endtask

    task automatic pulse_reset(input int n);
        @(posedge Clk);
        #2 Rst = 1'b1;
        repeat (n) @(posedge Clk);
        #2 Rst = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        int v0, e0;
        logic [13:0] tail;
        logic [DW-1:0] w;
        int len;

        wait_cycles(1);
        started = 1;
        wait_cycles(2);
        check("rst_data", 32'(Data), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_err_cnt", 32'(Err_cnt), 0);
        pulse_reset(1);

        // Full frame
        shift_word(32'h5A3C, DW);
        check("full_busy_before", 32'(Busy), 1);
        v0 = valid_seen;
        latch();
        check("full_valid_cnt", 32'(valid_seen - v0), 1);
        check("full_data", 32'(Data), 32'h5A3C);
        check("full_model", 32'(m_data), 32'h5A3C);
        check("full_err_cnt", 32'(Err_cnt), 0);
        check("full_busy", 32'(Busy), 0);

        // Back-to-back driver stream with a leading empty latch
        pulse_reset(2);
        hold = 4;
        cap_q.delete();
        latch();
        shift_word(32'h7FFF, DW); latch();
        shift_word(32'h0000, DW); latch();
        shift_word(32'h1234, DW); latch();
        check("b2b_count", 32'(cap_q.size()), 3);
        if (cap_q.size() == 3) begin
            check("b2b_w0", 32'(cap_q[0]), 32'h7FFF);
            check("b2b_w1", 32'(cap_q[1]), 32'h0000);
            check("b2b_w2", 32'(cap_q[2]), 32'h1234);
        end
        check("b2b_err_cnt", 32'(Err_cnt), 0);
        hold = 2;

        // Underrun then overrun
        e0 = err_seen;
        v0 = valid_seen;
        shift_word(32'h1FF, 9); latch();
        check("under_err", 32'(err_seen - e0), 1);
        check("under_err_cnt", 32'(Err_cnt), 1);
        check("under_data", 32'(Data), 32'h1234);
        check("under_busy", 32'(Busy), 0);
        shift_word(32'h1ABCD, 17); latch();
        check("over_err", 32'(err_seen - e0), 2);
        check("over_err_cnt", 32'(Err_cnt), 2);
        check("over_no_valid", 32'(valid_seen - v0), 0);
        shift_word(32'h0001, DW); latch();
        check("over_next_data", 32'(Data), 32'h0001);
        check("over_next_valid", 32'(valid_seen - v0), 1);

        // Coincident SH_CP/ST_CP
        shift_word(32'h2AAA, DW);
        coincident(1'b1);
        check("coin_data", 32'(Data), 32'h2AAA);
        check("coin_busy", 32'(Busy), 1);
        tail = 14'($urandom);
        shift_word(32'(tail), 14); latch();
        check("coin_next", 32'(Data), 32'({1'b1, tail}));
        check("coin_err_cnt", 32'(Err_cnt), 2);

        // Reset mid-frame
        shift_word(32'h55, 7);
        pulse_reset(2);
        v0 = valid_seen;
        e0 = err_seen;
        latch();
        check("rmid_valid", 32'(valid_seen - v0), 0);
        check("rmid_err", 32'(err_seen - e0), 0);
        check("rmid_data", 32'(Data), 0);
        check("rmid_err_cnt", 32'(Err_cnt), 0);
        check("rmid_busy", 32'(Busy), 0);

        // Randomised frames; model checks every cycle
        for (int n = 0; n < 60; n++) begin
            hold = $urandom_range(2, 4);
            len = ($urandom_range(0, 9) < 6) ? DW : $urandom_range(0, DW + 3);
            w = DW'($urandom);
            for (int i = 0; i < len; i++) shift_bit(w[i % DW]);
            if ($urandom_range(0, 7) == 0) coincident(1'($urandom));
            else latch();
        end
        hold = 2;

        // Error counter saturation
        for (int n = 0; n < 260; n++) begin
            shift_bit(1'($urandom));
            latch();
        end
        check("sat_err_cnt", 32'(Err_cnt), 32'hFF);
        check("sat_model", 32'(m_err_cnt), 32'hFF);
        shift_word(32'h4321, DW); latch();
        check("sat_data", 32'(Data), 32'h4321);
        check("sat_hold", 32'(Err_cnt), 32'hFF);

        wait_cycles(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hc595_frame_receiver.md
Name: hc595_frame_receiver

Overview:
- Receive end of the 74HC595 three-wire serial link (SH_CP shift clock, ST_CP latch clock, DS serial data), as emitted by the team's HC595 driver.
- Synchronises the three asynchronous inputs into Clk and deserialises MSB-first frames. On each ST_CP rising edge, presents the latched parallel word with a one-cycle valid strobe.
- Used for board-to-board loopback of the display link and as a self-check monitor in system benches. Malformed frames are flagged and counted.

Parameters:
- DATA_WIDTH, 15: bits per frame; also the width of Data.
- SYNC_STAGES, 2: synchroniser flops per input, minimum 2.
- ERR_CNT_W, 8: width of the saturating frame-error counter.

Ports:
- Clk  input  1  system clock. Must be at least 4x the SH_CP toggle rate.
- Rst  input  1  asynchronous, active-high reset.
- SH_CP  input  1  serial shift clock, asynchronous to Clk.
- ST_CP  input  1  latch clock, asynchronous to Clk.
- DS  input  1  serial data, MSB first.
- Data  output  DATA_WIDTH  last correctly framed word.
- Data_valid  output  1  one-cycle pulse when Data updates.
- Frame_err  output  1  one-cycle pulse on a bad-length frame.
- Err_cnt  output  ERR_CNT_W  saturating count of Frame_err pulses.
- Busy  output  1  high while a partial frame is held (bit_cnt != 0).

Behaviour:
- Interface: one clock, Clk. Reset Rst is asynchronous and active-high.
- Reset values:
  - Data = 0, Data_valid = 0, Frame_err = 0, Err_cnt = 0, Busy = 0.
  - Shift register = 0, bit_cnt = 0.
  - All synchroniser and edge-history flops = 0.
- Synchronisation:
  - SH_CP, ST_CP and DS each pass through an identical SYNC_STAGES flop chain, so DS stays aligned with the clocks.
  - One further history flop per clock input.
  - Rising edge = synchronised value 1 and history value 0. Falling edges are ignored.
- Shift, on each SH_CP rising edge:
  - shift_reg <= {shift_reg[DATA_WIDTH-2:0], DS_sync}.
  - bit_cnt increments, saturating at DATA_WIDTH+1 (overrun marker).
  - bit_cnt is ceil(log2(DATA_WIDTH+2)) bits wide.
- Latch, on each ST_CP rising edge, evaluated against the pre-edge bit_cnt:
  - bit_cnt == 0: no action, no Data_valid, no error. This absorbs the driver's empty latch after reset.
  - bit_cnt == DATA_WIDTH: Data <= shift_reg and Data_valid = 1 for exactly one Clk cycle.
  - Any other nonzero bit_cnt (underrun 1..DATA_WIDTH-1, or overrun DATA_WIDTH+1): Data holds, Frame_err = 1 for one cycle, Err_cnt increments, saturating at all-ones.
  - In all cases bit_cnt is then cleared.
- Simultaneous SH_CP and ST_CP rising edges in the same cycle:
  - The latch decision uses the old shift_reg and bit_cnt.
  - The new bit starts the next frame: bit_cnt becomes 1 and shift_reg holds the new bit in LSB.
- Latency: Data, Data_valid and Frame_err update on the (SYNC_STAGES+1)th Clk rising edge after the pin edge is first sampled high. That is 3 edges at the default.
- Data_valid and Frame_err are registered and mutually exclusive.
- Busy = (bit_cnt != 0), registered.
- Rst asserted mid-frame: all state returns to reset values immediately. The partial frame is discarded, and the next ST_CP with bit_cnt == 0 is silent.
- No back-pressure. A new frame overwrites Data; the consumer samples it on Data_valid.

Test Plan:
- Full frame: after reset, shift 15'h5A3C MSB first (15 SH_CP rises with DS stable across each rise), then pulse ST_CP → one Data_valid pulse, Data == 15'h5A3C, Frame_err 0, Err_cnt 0, Busy falls.
- Back-to-back stream from the HC595 driver (CNT_MAX=4): words 15'h7FFF, 15'h0000, 15'h1234 → three Data_valid pulses with matching Data. The leading empty latch produces no pulse.
- Underrun: 9 shifts then ST_CP → Frame_err pulse, Err_cnt 1, Data keeps its previous value, bit_cnt returns to 0.
- Overrun: 17 shifts then ST_CP → Frame_err pulse, Err_cnt increments. Next well-formed 15'h0001 frame → Data_valid, Data == 15'h0001.
- Coincident edges: after 15 shifts of 15'h2AAA, drive SH_CP and ST_CP rising in the same Clk cycle with DS=1 → Data == 15'h2AAA and Busy stays 1. The following 14 shifts plus ST_CP complete a valid frame whose MSB is 1.
- Reset mid-frame: 7 shifts, assert Rst for 2 cycles, then ST_CP → no Data_valid, no Frame_err, all outputs at reset values.
